// File: rtl/uart_program_loader.sv
// uart_program_loader: receives a framed program over an 8N1 UART line and
// writes it word by word into the CPU instruction memory while holding the CPU.
// Frame: 0xA5 sync, word count N, then 4*N data bytes (little-endian words).
// Optional feature macro UART_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// must match before the load is declared done.
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT    = 87,
    parameter int unsigned INSTR_MEM_DEPTH = 128,
    localparam int unsigned ADDR_W = (INSTR_MEM_DEPTH > 1) ? $clog2(INSTR_MEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [7:0]  SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

`ifdef UART_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_COUNT,
        GET_DATA,
        GET_CSUM,
        DONE
    } p_state_e;
`else
    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_COUNT,
        GET_DATA,
        DONE
    } p_state_e;
`endif

    // Synchronizer and edge-detect history
    logic rx_meta_q, rx_sync_q, rx_prev_q;

    // Bit engine state
    rx_state_e        rx_state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       rx_byte_q;
    logic             byte_valid_q;
    logic             frame_err_q;

    // Protocol state
    p_state_e          p_state_q;
    logic [7:0]        count_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       asm_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              cpu_hold_q;
    logic              load_done_q;
    logic              load_err_q;
`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    logic last_word;
    assign last_word = (32'(mem_addr_q) + 32'd1) == 32'(count_q);

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit engine: mid-bit sampling, emits byte_valid or frame_err pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            rx_byte_q    <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    cnt_q <= '0;
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line already back high is a glitch, not a start bit
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q     <= '0;
                        rx_byte_q <= {rx_sync_q, rx_byte_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                        cnt_q        <= '0;
                        byte_valid_q <= rx_sync_q;
                        frame_err_q  <= !rx_sync_q;
                        rx_state_q   <= RX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // Protocol FSM: frame parsing, word assembly and memory write sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state_q   <= WAIT_SYNC;
            count_q     <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            if (frame_err_q) begin
                // Drop any partial word; words already written stay in memory
                p_state_q   <= WAIT_SYNC;
                byte_idx_q  <= '0;
                load_err_q  <= 1'b1;
                load_done_q <= 1'b0;
                cpu_hold_q  <= 1'b1;
            end else begin
                case (p_state_q)
                    WAIT_SYNC: begin
                        if (byte_valid_q && rx_byte_q == SYNC_BYTE) begin
                            p_state_q  <= GET_COUNT;
                            load_err_q <= 1'b0;
                        end
                    end
                    GET_COUNT: begin
                        if (byte_valid_q) begin
                            if (rx_byte_q == 8'd0 || 32'(rx_byte_q) > INSTR_MEM_DEPTH) begin
                                load_err_q <= 1'b1;
                                p_state_q  <= WAIT_SYNC;
                            end else begin
                                count_q    <= rx_byte_q;
                                mem_addr_q <= '0;
                                byte_idx_q <= '0;
`ifdef UART_LOADER_CHECKSUM_EN
                                csum_q     <= '0;
`endif
                                p_state_q  <= GET_DATA;
                            end
                        end
                    end
                    GET_DATA: begin
                        if (mem_we_q) begin
                            // Write cycle just completed: advance or finish without wrapping
                            if (last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
                                p_state_q <= GET_CSUM;
`else
                                p_state_q   <= DONE;
                                load_done_q <= 1'b1;
                                cpu_hold_q  <= 1'b0;
`endif
                            end else begin
                                mem_addr_q <= mem_addr_q + ADDR_W'(1);
                            end
                        end else if (byte_valid_q) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            csum_q <= csum_q ^ rx_byte_q;
`endif
                            if (byte_idx_q == 2'd3) begin
                                mem_wdata_q <= {rx_byte_q, asm_q};
                                mem_we_q    <= 1'b1;
                                byte_idx_q  <= '0;
                            end else begin
                                asm_q      <= {rx_byte_q, asm_q[23:8]};
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end
                    end
`ifdef UART_LOADER_CHECKSUM_EN
                    GET_CSUM: begin
                        if (byte_valid_q) begin
                            if (rx_byte_q == csum_q) begin
                                p_state_q   <= DONE;
                                load_done_q <= 1'b1;
                                cpu_hold_q  <= 1'b0;
                            end else begin
                                load_err_q <= 1'b1;
                                p_state_q  <= WAIT_SYNC;
                            end
                        end
                    end
`endif
                    DONE: begin
                        if (byte_valid_q && rx_byte_q == SYNC_BYTE) begin
                            cpu_hold_q  <= 1'b1;
                            load_done_q <= 1'b0;
                            load_err_q  <= 1'b0;
                            p_state_q   <= GET_COUNT;
                        end
                    end
                    default: p_state_q <= WAIT_SYNC;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: directed UART frames, expected memory writes
// queued in a scoreboard and popped by an independent write monitor.
module tb_uart_program_loader;

    localparam int unsigned CLKS  = 8;
    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rx = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];

    uart_program_loader #(
        .CLKS_PER_BIT   (CLKS),
        .INSTR_MEM_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx  (uart_rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // Write monitor: every mem_we cycle must match the oldest expected write
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%08h expected no write", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", 32'(mem_addr), 32'(e.addr));
                    check("write_data", mem_wdata, e.data);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        uart_rx = 1'b0;
        repeat (CLKS) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLKS) @(posedge clk);
        end
        uart_rx = stop_ok;
        repeat (CLKS) @(posedge clk);
        uart_rx = 1'b1;
        repeat (2 * CLKS) @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i], 1'b1);
    endtask

    task automatic check_status(input string tag, input logic done_e, input logic hold_e, input logic err_e);
        @(negedge clk);
        check({tag, "_load_done"}, 32'(load_done), 32'(done_e));
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'(hold_e));
        check({tag, "_load_err"},  32'(load_err),  32'(err_e));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_we"},    32'(mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        check({tag, "_cpu_hold"},  32'(cpu_hold),  32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd0);
        check({tag, "_load_err"},  32'(load_err),  32'd0);
    endtask

    function automatic logic [7:0] xor_of(input logic [7:0] bytes[$]);
        logic [7:0] x = 8'h00;
        foreach (bytes[i]) x ^= bytes[i];
        return x;
    endfunction

    initial begin
        logic [7:0] prog[$];
        logic [7:0] word1[$];

        prog  = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        word1 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        // Reset values while reset is asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Short low glitch on idle line: nothing decoded
        uart_rx = 1'b0;
        repeat (CLKS / 4) @(posedge clk);
        uart_rx = 1'b1;
        repeat (3 * CLKS) @(posedge clk);
        check_status("glitch", 1'b0, 1'b1, 1'b0);

        // Framing error on the count byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b0);
        check_status("frame_err", 1'b0, 1'b1, 1'b1);

        // Reference two-word load
        exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 7'd1, data: 32'h0010_0093});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_seq(prog);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(xor_of(prog), 1'b1);
`endif
        check_status("load1", 1'b1, 1'b0, 1'b0);
        check("load1_pending", 32'(exp_q.size()), 32'd0);

        // Non-sync byte in DONE is ignored
        send_byte(8'h5A, 1'b1);
        check_status("done_ignore", 1'b1, 1'b0, 1'b0);

        // Sync re-arms the loader, then bad counts 0x00 and 0x81
        send_byte(8'hA5, 1'b1);
        check_status("resync", 1'b0, 1'b1, 1'b0);
        send_byte(8'h00, 1'b1);
        check_status("count0", 1'b0, 1'b1, 1'b1);
        send_byte(8'hA5, 1'b1);
        check_status("resync2", 1'b0, 1'b1, 1'b0);
        send_byte(8'h81, 1'b1);
        check_status("count81", 1'b0, 1'b1, 1'b1);

        // Reset pulse after two bytes of word 0
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check_reset_vals("midload_rst");
        repeat (2) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single-word load after reset
        exp_q.push_back('{addr: 7'd0, data: 32'hDEAD_BEEF});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_seq(word1);
`ifdef UART_LOADER_CHECKSUM_EN
        send_byte(xor_of(word1), 1'b1);
`endif
        check_status("load2", 1'b1, 1'b0, 1'b0);
        check("load2_pending", 32'(exp_q.size()), 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
        // Wrong checksum: words still written, load rejected
        exp_q.push_back('{addr: 7'd0, data: 32'h0000_0013});
        exp_q.push_back('{addr: 7'd1, data: 32'h0010_0093});
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_seq(prog);
        send_byte(8'h00, 1'b1);
        check_status("bad_csum", 1'b0, 1'b1, 1'b1);
        check("bad_csum_pending", 32'(exp_q.size()), 32'd0);
`endif

        repeat (4 * CLKS) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
